// File: rtl/mnd_pkg.sv
// Shared encodings and default latencies for the EXE-stage multiply/divide unit.
package mnd_pkg;

  localparam logic [1:0] MND_MULT  = 2'b00;
  localparam logic [1:0] MND_MULTU = 2'b01;
  localparam logic [1:0] MND_DIV   = 2'b10;
  localparam logic [1:0] MND_DIVU  = 2'b11;

  localparam logic MND_LO = 1'b0;
  localparam logic MND_HI = 1'b1;

  localparam int unsigned MND_MULT_CYCLES = 5;
  localparam int unsigned MND_DIV_CYCLES  = 10;

endpackage

// File: rtl/mnd_core.sv
// Combinational {hi,lo} = f(op, a, b); signed ops go through magnitudes so the
// 0x80000000 / -1 corner needs no special case.
module mnd_core
  import mnd_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] dvs_s;
  logic [31:0] dvs_u;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_u;
  logic [31:0] r_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign a_mag = a[31] ? (32'd0 - a) : a;
  assign b_mag = b[31] ? (32'd0 - b) : b;

  // Divisor forced to 1 on zero so the datapath never divides by zero.
  assign dvs_s = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign dvs_u = (b == 32'd0) ? 32'd1 : b;

  assign q_mag = a_mag / dvs_s;
  assign r_mag = a_mag % dvs_s;
  assign q_u   = a / dvs_u;
  assign r_u   = a % dvs_u;

  assign div_zero = op[1] && (b == 32'd0);

  always_comb begin
    hi = 32'd0;
    lo = 32'd0;
    unique case (op)
      MND_MULT:  {hi, lo} = prod_s;
      MND_MULTU: {hi, lo} = prod_u;
      MND_DIV: begin
        lo = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
        hi = a[31] ? (32'd0 - r_mag) : r_mag;
      end
      default: begin
        lo = q_u;
        hi = r_u;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide with architectural HI/LO, MTHI/MTLO writes and
// MFHI/MFLO read path; Busy drives the ID-stage stall.
module mult_div_unit
  import mnd_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MND_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MND_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  MnDOp_E,
  input  logic        MnDStart_E,
  input  logic        MnDWe_E,
  input  logic        MnDHiLo_E,
  input  logic [31:0] A_E,
  input  logic [31:0] B_E,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MnDOut_E
);

  localparam int unsigned MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_ok;

  logic [31:0] core_hi;
  logic [31:0] core_lo;
  logic        core_dz;

  mnd_core u_core (
    .op       (MnDOp_E),
    .a        (A_E),
    .b        (B_E),
    .hi       (core_hi),
    .lo       (core_lo),
    .div_zero (core_dz)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      res_ok <= 1'b0;
      HI     <= 32'd0;
      LO     <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (MnDStart_E) begin
            res_hi <= core_hi;
            res_lo <= core_lo;
            res_ok <= !core_dz;
            cnt    <= MnDOp_E[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state  <= RUN;
          end else if (MnDWe_E) begin
            if (MnDHiLo_E == MND_HI) HI <= A_E;
            else                     LO <= A_E;
          end
        end
        default: begin
          // A register write mid-op aborts it; the pending result is dropped.
          if (MnDWe_E) begin
            if (MnDHiLo_E == MND_HI) HI <= A_E;
            else                     LO <= A_E;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              if (res_ok) begin
                HI <= res_hi;
                LO <= res_lo;
              end
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign Busy     = (state == RUN);
  assign MnDOut_E = MnDHiLo_E ? HI : LO;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit; all tasks start and end on a negedge.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic [1:0]  MnDOp_E;
  logic        MnDStart_E;
  logic        MnDWe_E;
  logic        MnDHiLo_E;
  logic [31:0] A_E;
  logic [31:0] B_E;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MnDOut_E;

  int n_checks;
  int n_fail;

  mult_div_unit dut (
    .clk        (clk),
    .reset      (reset),
    .MnDOp_E    (MnDOp_E),
    .MnDStart_E (MnDStart_E),
    .MnDWe_E    (MnDWe_E),
    .MnDHiLo_E  (MnDHiLo_E),
    .A_E        (A_E),
    .B_E        (B_E),
    .Busy       (Busy),
    .HI         (HI),
    .LO         (LO),
    .MnDOut_E   (MnDOut_E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    MnDOp_E = op; A_E = a; B_E = b; MnDWe_E = 1'b0; MnDStart_E = 1'b1;
    @(negedge clk);
    MnDStart_E = 1'b0;
  endtask

  task automatic mt(input logic sel, input logic [31:0] v);
    MnDHiLo_E = sel; A_E = v; MnDWe_E = 1'b1;
    @(negedge clk);
    MnDWe_E = 1'b0;
  endtask

  // Counts cycles with Busy high, starting from the cycle after the start edge.
  task automatic busy_len(output int n);
    n = 0;
    while (Busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", Busy); end
    n_checks++; if (HI !== 32'd0) begin n_fail++; $display("FAIL reset_hi got=%h exp=0", HI); end
    n_checks++; if (LO !== 32'd0) begin n_fail++; $display("FAIL reset_lo got=%h exp=0", LO); end
    n_checks++; if (MnDOut_E !== 32'd0) begin n_fail++; $display("FAIL reset_out got=%h exp=0", MnDOut_E); end
  endtask

  task automatic test_mult;
    int n;
    start_op(2'b00, 32'hFFFF_FFFE, 32'd3);
    busy_len(n);
    n_checks++; if (n != 5) begin n_fail++; $display("FAIL mult_busy got=%0d exp=5", n); end
    n_checks++; if (HI !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
    n_checks++; if (LO !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult_lo got=%h exp=fffffffa", LO); end
  endtask

  task automatic test_multu_divu;
    int n;
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    busy_len(n);
    n_checks++; if (HI !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi got=%h exp=fffffffe", HI); end
    n_checks++; if (LO !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo got=%h exp=1", LO); end
    start_op(2'b11, 32'd100, 32'd7);
    busy_len(n);
    n_checks++; if (n != 10) begin n_fail++; $display("FAIL divu_busy got=%0d exp=10", n); end
    n_checks++; if (LO !== 32'd14) begin n_fail++; $display("FAIL divu_lo got=%h exp=e", LO); end
    n_checks++; if (HI !== 32'd2) begin n_fail++; $display("FAIL divu_hi got=%h exp=2", HI); end
  endtask

  task automatic test_div_signed;
    int n;
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    busy_len(n);
    n_checks++; if (LO !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo got=%h exp=fffffffd", LO); end
    n_checks++; if (HI !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi got=%h exp=ffffffff", HI); end
    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    busy_len(n);
    n_checks++; if (LO !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo got=%h exp=80000000", LO); end
    n_checks++; if (HI !== 32'd0) begin n_fail++; $display("FAIL div_ovf_hi got=%h exp=0", HI); end
  endtask

  task automatic test_div_zero;
    int n;
    mt(1'b1, 32'h11);
    mt(1'b0, 32'h22);
    n_checks++; if (HI !== 32'h11 || LO !== 32'h22) begin n_fail++; $display("FAIL mt_preset got=%h/%h exp=11/22", HI, LO); end
    start_op(2'b11, 32'd1234, 32'd0);
    busy_len(n);
    n_checks++; if (n != 10) begin n_fail++; $display("FAIL divz_busy got=%0d exp=10", n); end
    n_checks++; if (HI !== 32'h11 || LO !== 32'h22) begin n_fail++; $display("FAIL divu_zero got=%h/%h exp=11/22", HI, LO); end
    start_op(2'b10, 32'hFFFF_0000, 32'd0);
    busy_len(n);
    n_checks++; if (HI !== 32'h11 || LO !== 32'h22) begin n_fail++; $display("FAIL div_zero got=%h/%h exp=11/22", HI, LO); end
    MnDHiLo_E = 1'b1; #1;
    n_checks++; if (MnDOut_E !== 32'h11) begin n_fail++; $display("FAIL out_hi got=%h exp=11", MnDOut_E); end
    MnDHiLo_E = 1'b0; #1;
    n_checks++; if (MnDOut_E !== 32'h22) begin n_fail++; $display("FAIL out_lo got=%h exp=22", MnDOut_E); end
    @(negedge clk);
  endtask

  task automatic test_start_we;
    int n;
    MnDHiLo_E = 1'b0; MnDWe_E = 1'b1;
    MnDOp_E = 2'b01; A_E = 32'd6; B_E = 32'd7; MnDStart_E = 1'b1;
    @(negedge clk);
    MnDStart_E = 1'b0; MnDWe_E = 1'b0;
    n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL sw_busy got=%0b exp=1", Busy); end
    n_checks++; if (LO !== 32'h22) begin n_fail++; $display("FAIL sw_dropped got=%h exp=22", LO); end
    busy_len(n);
    n_checks++; if (n != 5) begin n_fail++; $display("FAIL sw_len got=%0d exp=5", n); end
    n_checks++; if (LO !== 32'd42 || HI !== 32'd0) begin n_fail++; $display("FAIL sw_result got=%h/%h exp=0/2a", HI, LO); end
  endtask

  task automatic test_abort;
    mt(1'b1, 32'hAA);
    start_op(2'b11, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre got=%0b exp=1", Busy); end
    mt(1'b0, 32'h55);
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%0b exp=0", Busy); end
    n_checks++; if (LO !== 32'h55 || HI !== 32'hAA) begin n_fail++; $display("FAIL abort_regs got=%h/%h exp=aa/55", HI, LO); end
    repeat (12) @(negedge clk);
    n_checks++; if (LO !== 32'h55 || HI !== 32'hAA) begin n_fail++; $display("FAIL abort_late got=%h/%h exp=aa/55", HI, LO); end
  endtask

  task automatic test_reset_mid;
    int n;
    mt(1'b1, 32'h77);
    start_op(2'b00, 32'd5, 32'd5);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid got=%0b/%h/%h exp=0/0/0", Busy, HI, LO);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_op(2'b00, 32'd5, 32'd5);
    busy_len(n);
    n_checks++; if (n != 5 || LO !== 32'd25 || HI !== 32'd0) begin
      n_fail++; $display("FAIL reset_restart got=%0d/%h/%h exp=5/0/19", n, HI, LO);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    start_op(2'b01, 32'd3, 32'd4);
    busy_len(n);
    n_checks++; if (LO !== 32'd12) begin n_fail++; $display("FAIL b2b_first got=%h exp=c", LO); end
    start_op(2'b11, 32'd9, 32'd2);
    busy_len(n);
    n_checks++; if (n != 10 || LO !== 32'd4 || HI !== 32'd1) begin
      n_fail++; $display("FAIL b2b_second got=%0d/%h/%h exp=10/1/4", n, HI, LO);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; MnDOp_E = 2'b00; MnDStart_E = 1'b0; MnDWe_E = 1'b0;
    MnDHiLo_E = 1'b0; A_E = 32'd0; B_E = 32'd0;
    repeat (2) @(negedge clk);
    test_reset;
    reset = 1'b0;
    @(negedge clk);
    test_mult;
    test_multu_divu;
    test_div_signed;
    test_div_zero;
    test_start_we;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
